// File: rtl/usb_xfer_sched.sv
// usb_xfer_sched: 1 ms frame timebase with SOF requests, round-robin grant of two
// transfer requesters, single-transaction launch with bounded retry and EOF guard.
module usb_xfer_sched #(
  parameter int FRAME_CYCLES = 12000,
  parameter int GUARD_CYCLES = 600,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sof_enable,
  input  logic [1:0]  req_valid,
  input  logic [3:0]  req0_endpoint,
  input  logic [3:0]  req1_endpoint,
  input  logic [1:0]  req0_type,
  input  logic [1:0]  req1_type,
  output logic [1:0]  req_ack,
  output logic        xfer_start,
  output logic        xfer_port,
  output logic [3:0]  xfer_endpoint,
  output logic [1:0]  xfer_type,
  output logic        sof_start,
  input  logic        xfer_done_pulse,
  input  logic        timeout,
  input  logic        crc16_valid,
  output logic [1:0]  resp_done,
  output logic        resp_error,
  output logic [10:0] frame_number,
  output logic        busy
);
  localparam int CW = $clog2(FRAME_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT_DONE = 2'd2, SOF_WAIT = 2'd3;
  logic [1:0] state;
  logic [CW-1:0] frame_cnt;
  logic [RW-1:0] retries;
  logic sof_pending, last_grant;
  logic wrap, guard, grant, ok, sof_go;
  assign wrap = sof_enable && frame_cnt == CW'(FRAME_CYCLES - 1);
  assign guard = frame_cnt >= CW'(FRAME_CYCLES - GUARD_CYCLES);
  assign grant = req_valid == 2'b11 ? ~last_grant : req_valid[1];
  assign ok = !timeout && crc16_valid;
  assign sof_go = state == IDLE && sof_pending;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      frame_cnt <= '0;
      frame_number <= '0;
      sof_pending <= 1'b0;
      last_grant <= 1'b1;
      retries <= '0;
      req_ack <= '0;
      xfer_start <= 1'b0;
      sof_start <= 1'b0;
      resp_done <= '0;
      resp_error <= 1'b0;
      xfer_port <= 1'b0;
      xfer_endpoint <= '0;
      xfer_type <= '0;
    end else begin
      req_ack <= '0;
      xfer_start <= 1'b0;
      sof_start <= 1'b0;
      resp_done <= '0;
      resp_error <= 1'b0;
      frame_cnt <= (!sof_enable || wrap) ? '0 : frame_cnt + 1'b1;
      // a wrap while a SOF is already pending is dropped
      sof_pending <= sof_enable && !sof_go && (sof_pending || wrap);
      case (state)
        IDLE:
          if (sof_pending) begin
            sof_start <= 1'b1;
            frame_number <= frame_number + 11'd1;
            state <= SOF_WAIT;
          end else if (|req_valid && !guard) begin
            req_ack <= grant ? 2'b10 : 2'b01;
            xfer_port <= grant;
            xfer_endpoint <= grant ? req1_endpoint : req0_endpoint;
            xfer_type <= grant ? req1_type : req0_type;
            retries <= '0;
            state <= START;
          end
        START: begin
          xfer_start <= 1'b1;
          state <= WAIT_DONE;
        end
        WAIT_DONE:
          if (xfer_done_pulse) begin
            if (!ok && retries != RW'(MAX_RETRY)) begin
              retries <= retries + 1'b1;
              state <= START;
            end else begin
              resp_done <= xfer_port ? 2'b10 : 2'b01;
              resp_error <= !ok;
              last_grant <= xfer_port;
              state <= IDLE;
            end
          end
        default: if (xfer_done_pulse) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_xfer_sched.sv
// tb_usb_xfer_sched: directed SOF/guard scenarios plus randomized transactions
// checked against a frame-position and round-robin reference model.
module tb_usb_xfer_sched;
  localparam int FC = 100, GC = 10, MR = 3;
  logic clk = 1'b0, rst_n = 1'b0, sof_enable = 1'b0;
  logic [1:0] req_valid = '0, req0_type = '0, req1_type = '0;
  logic [3:0] req0_endpoint = '0, req1_endpoint = '0;
  logic xfer_done_pulse = 1'b0, timeout = 1'b0, crc16_valid = 1'b0;
  logic [1:0] req_ack, resp_done, xfer_type;
  logic xfer_start, xfer_port, sof_start, resp_error, busy;
  logic [3:0] xfer_endpoint;
  logic [10:0] frame_number;
  int errors = 0, checks = 0, n = 0;
  logic last = 1'b1;
  usb_xfer_sched #(.FRAME_CYCLES(FC), .GUARD_CYCLES(GC), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .sof_enable(sof_enable), .req_valid(req_valid),
    .req0_endpoint(req0_endpoint), .req1_endpoint(req1_endpoint),
    .req0_type(req0_type), .req1_type(req1_type), .req_ack(req_ack),
    .xfer_start(xfer_start), .xfer_port(xfer_port), .xfer_endpoint(xfer_endpoint),
    .xfer_type(xfer_type), .sof_start(sof_start), .xfer_done_pulse(xfer_done_pulse),
    .timeout(timeout), .crc16_valid(crc16_valid), .resp_done(resp_done),
    .resp_error(resp_error), .frame_number(frame_number), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // n counts enabled frame cycles, so n % FC is the model frame position
  task automatic tick();
    @(posedge clk);
    if (sof_enable) n++;
    #1;
  endtask
  task automatic quiet(input string tag);
    chk(tag, {req_ack, xfer_start, sof_start, resp_done, resp_error}, 0);
  endtask
  task automatic xact(input logic [1:0] rv, input int nfail, input bit noise);
    logic g, fail;
    logic [3:0] e0, e1, ep;
    logic [1:0] t0, t1, ty;
    int last_a;
    e0 = 4'($urandom); e1 = 4'($urandom); t0 = 2'($urandom); t1 = 2'($urandom);
    req0_endpoint = e0; req1_endpoint = e1; req0_type = t0; req1_type = t1;
    g = rv == 2'b11 ? ~last : rv[1];
    ep = g ? e1 : e0;
    ty = g ? t1 : t0;
    last_a = nfail > MR ? MR : nfail;
    req_valid = rv;
    tick();
    chk("ack", 32'(req_ack), g ? 32'd2 : 32'd1);
    req_valid = '0;
    if (noise && $urandom_range(0, 1) == 1) begin
      xfer_done_pulse = 1'b1; timeout = 1'b1;
    end
    tick();
    xfer_done_pulse = 1'b0; timeout = 1'b0;
    chk("start", 32'(xfer_start), 1);
    chk("fields", {xfer_port, xfer_endpoint, xfer_type}, {g, ep, ty});
    for (int a = 0; a <= last_a; a++) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        quiet("wait_quiet");
        chk("wait_busy", 32'(busy), 1);
      end
      fail = a < nfail;
      xfer_done_pulse = 1'b1;
      if (!fail) begin timeout = 1'b0; crc16_valid = 1'b1; end
      else if ($urandom_range(0, 1) == 1) begin timeout = 1'b1; crc16_valid = 1'($urandom); end
      else begin timeout = 1'b0; crc16_valid = 1'b0; end
      tick();
      xfer_done_pulse = 1'b0; timeout = 1'b0; crc16_valid = 1'b0;
      if (a < last_a) begin
        quiet("retry_gap");
        tick();
        chk("retry_start", 32'(xfer_start), 1);
        chk("retry_fields", {xfer_port, xfer_endpoint, xfer_type}, {g, ep, ty});
      end else begin
        chk("resp_done", 32'(resp_done), g ? 32'd2 : 32'd1);
        chk("resp_error", 32'(resp_error), 32'(nfail > MR));
        last = g;
      end
    end
  endtask
  initial begin
    sof_enable = 1'b1; req_valid = 2'b11; xfer_done_pulse = 1'b1; timeout = 1'b1; crc16_valid = 1'b1;
    repeat (3) tick();
    quiet("rst_pulses");
    chk("rst_fields", {busy, xfer_port, xfer_endpoint, xfer_type, frame_number}, 0);
    rst_n = 1'b1; sof_enable = 1'b0; req_valid = '0; xfer_done_pulse = 1'b0; timeout = 1'b0; crc16_valid = 1'b0;
    n = 0;
    repeat (4) begin
      tick();
      quiet("post_rst");
      chk("post_rst_busy", 32'(busy), 0);
    end
    // SOF timebase: first wrap at n=FC, sof_start the cycle after
    sof_enable = 1'b1;
    while (n < 3 * FC + 5) begin
      tick();
      chk("sof_start", 32'(sof_start), 32'(n % FC == 1 && n > FC));
      chk("sof_busy", 32'(busy), 32'(n % FC == 1 && n > FC));
      if (n % FC == 1 && n > FC) chk("frame_number", 32'(frame_number), 32'(n / FC));
      xfer_done_pulse = n % FC == 1 && n > FC;
    end
    xfer_done_pulse = 1'b0;
    // guard window: request raised at frame position 95
    while (n % FC != 95) tick();
    req0_endpoint = 4'd5; req0_type = 2'd2; req_valid = 2'b01;
    while (n % FC != 3) begin
      tick();
      chk("guard_ack", 32'(req_ack), 32'(n % FC == 3));
      chk("guard_sof", 32'(sof_start), 32'(n % FC == 1));
      xfer_done_pulse = n % FC == 1;
    end
    req_valid = '0; xfer_done_pulse = 1'b0;
    tick();
    chk("guard_start", {xfer_start, xfer_port, xfer_endpoint, xfer_type}, {1'b1, 1'b0, 4'd5, 2'd2});
    xfer_done_pulse = 1'b1; crc16_valid = 1'b1;
    tick();
    xfer_done_pulse = 1'b0; crc16_valid = 1'b0;
    chk("guard_resp", {resp_done, resp_error}, {2'b01, 1'b0});
    last = 1'b0;
    // wrap during WAIT_DONE: SOF goes first, then the waiting request
    while (n % FC != 50) tick();
    req1_endpoint = 4'd9; req1_type = 2'd1; req_valid = 2'b10;
    tick();
    chk("sd_ack", 32'(req_ack), 2);
    req_valid = '0;
    tick();
    chk("sd_start", 32'(xfer_start), 1);
    req0_endpoint = 4'd3; req0_type = 2'd3; req_valid = 2'b01;
    while (n % FC != 2) begin
      tick();
      chk("sd_hold", {req_ack, sof_start, resp_done}, 0);
    end
    xfer_done_pulse = 1'b1; crc16_valid = 1'b1;
    tick();
    xfer_done_pulse = 1'b0; crc16_valid = 1'b0;
    chk("sd_resp", {resp_done, resp_error}, {2'b10, 1'b0});
    tick();
    chk("sd_sof", {sof_start, req_ack}, {1'b1, 2'b00});
    chk("sd_frame", 32'(frame_number), 5);
    xfer_done_pulse = 1'b1;
    tick();
    xfer_done_pulse = 1'b0;
    chk("sd_noack", 32'(req_ack), 0);
    tick();
    chk("sd_ack2", 32'(req_ack), 1);
    req_valid = '0;
    tick();
    chk("sd_start2", {xfer_start, xfer_port, xfer_endpoint, xfer_type}, {1'b1, 1'b0, 4'd3, 2'd3});
    xfer_done_pulse = 1'b1; crc16_valid = 1'b1;
    tick();
    xfer_done_pulse = 1'b0; crc16_valid = 1'b0;
    chk("sd_resp2", 32'(resp_done), 1);
    last = 1'b0;
    sof_enable = 1'b0;
    tick();
    // directed retry cases, then randomized traffic
    xact(2'b10, MR + 1, 1'b0);
    xact(2'b01, 1, 1'b0);
    xact(2'b11, 0, 1'b0);
    xact(2'b11, 0, 1'b0);
    xact(2'b11, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        xfer_done_pulse = 1'b1; timeout = 1'b1;
        tick();
        xfer_done_pulse = 1'b0; timeout = 1'b0;
        quiet("idle_done");
        chk("idle_busy", 32'(busy), 0);
      end
      xact(2'($urandom_range(1, 3)), $urandom_range(0, MR + 1), 1'b1);
    end
    // reset mid-transaction aborts silently and restores port-0 priority
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    tick();
    chk("mid_start", 32'(xfer_start), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst", {busy, xfer_port, xfer_endpoint, xfer_type, frame_number}, 0);
    xfer_done_pulse = 1'b1; crc16_valid = 1'b1;
    tick();
    xfer_done_pulse = 1'b0; crc16_valid = 1'b0;
    tick();
    quiet("mid_quiet");
    last = 1'b1;
    xact(2'b11, 0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
